// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and its consumer.
interface reset_sequencer_if #(
  parameter int N_CH = 4
);
  logic            sw_rst_req;
  logic [N_CH-1:0] ch_mask;
  logic [N_CH-1:0] rst_out;
  logic            busy;
  logic            done;
  logic [1:0]      state;

  modport master (output sw_rst_req, ch_mask, input rst_out, busy, done, state);
  modport slave  (input sw_rst_req, ch_mask, output rst_out, busy, done, state);
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises async reset release, holds all channels,
// then releases per-channel resets in a staggered order and reports RUN.

// One downstream reset channel: registered reset bit, released once the
// shared release counter reaches this channel's slot.
module reset_sequencer_ch #(
  parameter int CNT_W  = 1,
  parameter int REL_AT = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mask,
  input  logic             rel_phase,
  input  logic             run_phase,
  input  logic [CNT_W-1:0] cnt_d,
  output logic             rst_out
);
  logic rst_out_d, rst_out_q;

  // Release decision uses next-state info so the bit flips on the scheduled edge.
  always_comb begin
    rst_out_d = 1'b1;
    if (run_phase)                                  rst_out_d = 1'b0;
    else if (rel_phase && int'(cnt_d) >= REL_AT)    rst_out_d = 1'b0;
    if (mask)                                       rst_out_d = 1'b1;
  end

  // Channel reset flop; async reset forces it asserted.
  always_ff @(posedge clk or negedge rst)
    if (!rst) rst_out_q <= 1'b1;
    else      rst_out_q <= rst_out_d;

  assign rst_out = rst_out_q;
endmodule

module reset_sequencer #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 2,
  parameter int STAGGER     = 1
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.slave  bus
);
  // Release count at which the last channel goes; 0 means all release together.
  localparam int LAST    = (N_CH - 1) * STAGGER;
  localparam int CNT_MAX = (HOLD_CYCLES > LAST + 1) ? HOLD_CYCLES : LAST + 1;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RUN     = 2'd3
  } state_t;

  state_t                 state_d, state_q;
  logic [CNT_W-1:0]       cnt_d, cnt_q, cnt_inc;
  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic                   sync_out;
  logic                   done_d, done_q;
  logic                   rel_phase, run_phase;
  logic [N_CH-1:0]        rst_out_q;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // Release synchroniser: shifts in ones once rst is high.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Next-state, counter and done-pulse logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ASSERT: begin
        if (sync_out) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          // With a zero stagger the release-entry edge is also the RUN edge.
          state_d = (LAST == 0) ? ST_RUN : ST_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      ST_RELEASE: begin
        if (cnt_inc == CNT_W'(LAST)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_inc;
        end
      end
      default: ;
    endcase
    // Software reset restarts the hold window from any post-sync state.
    if (bus.sw_rst_req && state_q != ST_ASSERT) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
    end
    done_d = (state_d == ST_RUN) && (state_q != ST_RUN);
  end

  // Sequencer state registers.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      sync_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      done_q  <= done_d;
    end

  assign rel_phase = (state_d == ST_RELEASE);
  assign run_phase = (state_d == ST_RUN);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    reset_sequencer_ch #(
      .CNT_W  (CNT_W),
      .REL_AT (k * STAGGER)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .mask      (bus.ch_mask[k]),
      .rel_phase (rel_phase),
      .run_phase (run_phase),
      .cnt_d     (cnt_d),
      .rst_out   (rst_out_q[k])
    );
  end

  assign bus.rst_out = rst_out_q;
  assign bus.busy    = (state_q != ST_RUN);
  assign bus.done    = done_q;
  assign bus.state   = state_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed vector table, corner-case sequences
// and random traffic, all checked against an edge-count based model.
module tb_reset_sequencer;
  localparam int N    = 4;
  localparam int SYNC = 2;
  localparam int HOLD = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  reset_sequencer_if #(.N_CH(N)) if0 ();
  reset_sequencer_if #(.N_CH(N)) if1 ();
  assign if1.sw_rst_req = if0.sw_rst_req;
  assign if1.ch_mask    = if0.ch_mask;

  reset_sequencer #(.N_CH(N), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .STAGGER(1))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  reset_sequencer #(.N_CH(N), .SYNC_STAGES(SYNC), .HOLD_CYCLES(HOLD), .STAGGER(0))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  int n_chk  = 0;
  int n_fail = 0;
  int e      = 0;  // rising edges since rst went high
  int rel0   = 0;  // edge at which channel 0 is due to release
  logic [N-1:0] mask_s;

  typedef struct {
    logic         sw;
    logic [N-1:0] mask;
    logic [N-1:0] ro;
    logic [1:0]   st;
    logic         dn;
    logic [N-1:0] ro_s0;
    logic         dn_s0;
  } vec_t;
  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  // Phase from edge count: ASSERT until hold starts, HOLD until channel 0
  // is due, RELEASE until the last channel is due, then RUN.
  function automatic logic [1:0] m_state(input int ee, input int r0, input int s);
    int run_e;
    run_e = r0 + (N - 1) * s;
    if (ee < r0 - HOLD) return 2'd0;
    if (ee < r0)        return 2'd1;
    if (ee < run_e)     return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [N-1:0] m_rst(input int ee, input int r0, input int s, input logic [N-1:0] m);
    logic [N-1:0] r;
    for (int k = 0; k < N; k++) r[k] = m[k] | (ee < r0 + k * s);
    return r;
  endfunction

  task automatic model_check();
    logic [1:0] st1, st0;
    st1 = m_state(e, rel0, 1);
    st0 = m_state(e, rel0, 0);
    chk("s1_rst_out", 32'(if0.rst_out), 32'(m_rst(e, rel0, 1, mask_s)));
    chk("s1_state",   32'(if0.state),   32'(st1));
    chk("s1_done",    32'(if0.done),    32'(e == rel0 + (N - 1)));
    chk("s1_busy",    32'(if0.busy),    32'(st1 != 2'd3));
    chk("s0_rst_out", 32'(if1.rst_out), 32'(m_rst(e, rel0, 0, mask_s)));
    chk("s0_state",   32'(if1.state),   32'(st0));
    chk("s0_done",    32'(if1.done),    32'(e == rel0));
    chk("s0_busy",    32'(if1.busy),    32'(st0 != 2'd3));
  endtask

  // One clock: update the model with the inputs sampled at the edge, check at negedge.
  task automatic step();
    @(posedge clk);
    e++;
    if (if0.sw_rst_req && m_state(e - 1, rel0, 1) != 2'd0) rel0 = e + HOLD;
    mask_s = if0.ch_mask;
    @(negedge clk);
    model_check();
  endtask

  task automatic chk_rst_vals(input string tag);
    chk({tag, "_s1_rst_out"}, 32'(if0.rst_out), 32'({N{1'b1}}));
    chk({tag, "_s1_state"},   32'(if0.state),   32'd0);
    chk({tag, "_s1_busy"},    32'(if0.busy),    32'd1);
    chk({tag, "_s1_done"},    32'(if0.done),    32'd0);
    chk({tag, "_s0_rst_out"}, 32'(if1.rst_out), 32'({N{1'b1}}));
    chk({tag, "_s0_state"},   32'(if1.state),   32'd0);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst    = 1'b1;
    e      = 0;
    rel0   = SYNC + 1 + HOLD;
    mask_s = if0.ch_mask;
  endtask

  // Drop rst mid-cycle, check outputs before any clock edge, then release.
  task automatic async_rst(input int hold_edges);
    #2 rst = 1'b0;
    #1 chk_rst_vals("async");
    repeat (hold_edges) @(posedge clk);
    release_rst();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, edge %0d", e);
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    if0.sw_rst_req = 1'b0;
    if0.ch_mask    = '0;
    #1 rst = 1'b0;
    #1 chk_rst_vals("por");
    repeat (2) @(posedge clk);
    release_rst();

    // Default sequence with sw_rst_req held during ASSERT (edges 1..3).
    //          sw    mask     ro       st    dn    ro_s0    dn_s0
    tbl[0] = '{1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0, 4'b1111, 1'b0};
    tbl[1] = '{1'b1, 4'b0000, 4'b1111, 2'd0, 1'b0, 4'b1111, 1'b0};
    tbl[2] = '{1'b1, 4'b0000, 4'b1111, 2'd1, 1'b0, 4'b1111, 1'b0};
    tbl[3] = '{1'b0, 4'b0000, 4'b1111, 2'd1, 1'b0, 4'b1111, 1'b0};
    tbl[4] = '{1'b0, 4'b0000, 4'b1110, 2'd2, 1'b0, 4'b0000, 1'b1};
    tbl[5] = '{1'b0, 4'b0000, 4'b1100, 2'd2, 1'b0, 4'b0000, 1'b0};
    tbl[6] = '{1'b0, 4'b0000, 4'b1000, 2'd2, 1'b0, 4'b0000, 1'b0};
    tbl[7] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b1, 4'b0000, 1'b0};
    tbl[8] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0};
    tbl[9] = '{1'b0, 4'b0000, 4'b0000, 2'd3, 1'b0, 4'b0000, 1'b0};
    for (int i = 0; i < 10; i++) begin
      if0.sw_rst_req = tbl[i].sw;
      if0.ch_mask    = tbl[i].mask;
      step();
      chk("tbl_ro",    32'(if0.rst_out), 32'(tbl[i].ro));
      chk("tbl_st",    32'(if0.state),   32'(tbl[i].st));
      chk("tbl_dn",    32'(if0.done),    32'(tbl[i].dn));
      chk("tbl_ro_s0", 32'(if1.rst_out), 32'(tbl[i].ro_s0));
      chk("tbl_dn_s0", 32'(if1.done),    32'(tbl[i].dn_s0));
    end

    // Software reset pulse in RUN.
    if0.sw_rst_req = 1'b1;
    step();
    if0.sw_rst_req = 1'b0;
    chk("sw_t_st", 32'(if0.state),   32'd1);
    chk("sw_t_ro", 32'(if0.rst_out), 32'hf);
    repeat (2) step();
    chk("sw_t2_ro", 32'(if0.rst_out), 32'he);
    repeat (3) step();
    chk("sw_t5_ro", 32'(if0.rst_out), 32'h0);
    chk("sw_t5_dn", 32'(if0.done),    32'd1);

    // Async reset in the middle of RELEASE, then a full rerun.
    async_rst(2);
    repeat (6) step();
    chk("mid_rel_ro", 32'(if0.rst_out), 32'hc);
    chk("mid_rel_st", 32'(if0.state),   32'd2);
    async_rst(2);
    for (int i = 0; i < 10; i++) begin
      step();
      if (e == 8) chk("rerun_dn", 32'(if0.done), 32'd1);
    end

    // Masked channel does not delay RUN; unmasking in RUN releases next edge.
    if0.ch_mask = 4'b0100;
    async_rst(2);
    repeat (8) step();
    chk("mask_st", 32'(if0.state),   32'd3);
    chk("mask_ro", 32'(if0.rst_out), 32'h4);
    chk("mask_dn", 32'(if0.done),    32'd1);
    if0.ch_mask = '0;
    step();
    chk("unmask_ro", 32'(if0.rst_out), 32'h0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 79) == 0) async_rst(int'($urandom_range(1, 3)));
      if0.sw_rst_req = ($urandom_range(0, 11) == 0);
      if0.ch_mask    = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 Parameter N_CH, default 4: number of downstream reset channels; legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: deassertion synchroniser depth; legal minimum 2.
REQ-003 Parameter HOLD_CYCLES, default 2: cycles all channels stay asserted after synchronised release; legal minimum 1.
REQ-004 Parameter STAGGER, default 1: cycles between consecutive channel releases; 0 means all channels release together.
REQ-005 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-006 Port rst, input, 1: reset, asynchronous and active-low.
REQ-007 Port sw_rst_req, input, 1: synchronous software reset request, sampled each rising edge.
REQ-008 Port ch_mask, input, N_CH: bit k = 1 forces rst_out[k] asserted.
REQ-009 Port rst_out, output, N_CH: per-channel active-high reset for datapath blocks, registered.
REQ-010 Port busy, output, 1: high in every state except RUN.
REQ-011 Port done, output, 1: one-cycle pulse on entry to RUN.
REQ-012 Port state, output, 2: current FSM state; ASSERT=0, HOLD=1, RELEASE=2, RUN=3.

Function
REQ-013 FSM states SHALL be ASSERT, HOLD, RELEASE, RUN, with one internal counter cnt sized to cover max(HOLD_CYCLES, (N_CH-1)*STAGGER+1).
REQ-014 rst low SHALL asynchronously force state=ASSERT, cnt=0, synchroniser=0, rst_out=all ones, busy=1, done=0.
REQ-015 Deassertion of rst SHALL pass through SYNC_STAGES flops; synchroniser output high after the SYNC_STAGES-th rising edge with rst high.
REQ-016 ASSERT -> HOLD on the first edge with synchroniser output high; cnt=0.
REQ-017 HOLD: cnt increments each edge; HOLD -> RELEASE on the edge at which HOLD_CYCLES edges have elapsed in HOLD; cnt=0 on entry.
REQ-018 RELEASE: rst_out[k] SHALL deassert on the edge at which the RELEASE cycle count equals k*STAGGER, channel 0 on the RELEASE-entry edge.
REQ-019 RELEASE -> RUN on the same edge that releases channel N_CH-1; with STAGGER=0 or N_CH=1 this is the RELEASE-entry edge itself.
REQ-020 Last channel release edge, counted from first rst-high edge = 1, SHALL equal SYNC_STAGES+1+HOLD_CYCLES+(N_CH-1)*STAGGER.
REQ-021 done SHALL be high exactly for the cycle following the RUN-entry edge, low otherwise.
REQ-022 sw_rst_req high in RUN, RELEASE or HOLD SHALL on that edge set state=HOLD, cnt=0, rst_out=all ones, done=0; in HOLD this restarts the hold count.
REQ-023 sw_rst_req SHALL be ignored in ASSERT and while rst is low.
REQ-024 ch_mask[k]=1 SHALL hold rst_out[k]=1 on every edge regardless of state; clearing it in RUN deasserts rst_out[k] on the next edge; clearing it in HOLD/RELEASE follows normal schedule.
REQ-025 FSM progression SHALL not depend on ch_mask; masked channels do not delay RUN entry.
REQ-026 rst asserted mid-sequence (any state) SHALL abort immediately per REQ-014; sequence restarts from ASSERT.

Reset
REQ-027 Reset values: state=0, cnt=0, synchroniser=0, rst_out=all ones, busy=1, done=0.
REQ-028 No output SHALL glitch low between async assertion and synchronised release.

Verification
REQ-029 Defaults, rst low 2 cycles then high -> rst_out 4'b1111 until edge 5; bits 0,1,2,3 fall at edges 5,6,7,8; state=3 and done=1 for cycle after edge 8; busy=0 thereafter.
REQ-030 STAGGER=0, N_CH=4 -> rst_out 4'b1111 -> 4'b0000 on edge 5; done pulse after edge 5.
REQ-031 sw_rst_req pulse in RUN at edge t -> rst_out=4'b1111, state=1 after t; rst_out[0] falls at t+2, rst_out[3] at t+5, done after t+5.
REQ-032 rst driven low mid-RELEASE (after edge 6) -> rst_out=4'b1111, state=0, busy=1 immediately without clock; full sequence repeats after release.
REQ-033 ch_mask=4'b0100 throughout -> rst_out[2] stays 1, RUN entered at edge 8; mask cleared in RUN at edge t -> rst_out=4'b0000 after t+1.
REQ-034 sw_rst_req held high during ASSERT -> no effect; sequence timing identical to REQ-029.
